attn_out_stream_writer: RTL
===========================

Name: attn_out_stream_writer

Overview:
- Sink for the attention-output stream: one 128-bit vector per (row, tile), 4 rows x 32 tiles = 128 vectors per frame.
- Buffers incoming beats in a small FIFO and writes each one into a single-port output SRAM through a granted write port.
- Address = O_BASE + row*32 + tile.
- Tracks which of the 128 slots were written, flags protocol errors and pulses frame_done when the frame is complete.
- Sits between the 4x4·4x128 multi-head GEMM stream output and the output/O-projection SRAM.

Parameters:
- FIFO_DEPTH, 4, input buffer entries; power of 2, >= 2.
- O_BASE, 7'd0, base word address of the output matrix in SRAM.
- SLOTS, 128, vectors per frame; fixed at 4 rows x 32 tiles.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- frame_start  in  1  1-cycle pulse; clears frame state and flushes the FIFO
- in_vec  in  128  streamed vector {lane3,lane2,lane1,lane0}, FP32 lanes
- in_row  in  2  output row 0..3
- in_tile  in  5  output tile 0..31
- in_valid  in  1  beat valid; no backpressure to producer
- O_mem_addr  out  7  SRAM write address
- O_mem_wdata  out  128  SRAM write data
- O_mem_we  out  1  write request
- O_mem_gnt  in  1  arbiter grant; a write commits on a cycle with O_mem_we && O_mem_gnt
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently buffered
- written_cnt  out  8  distinct slots committed this frame, 0..128
- busy  out  1  FIFO non-empty or write stage occupied
- frame_done  out  1  1-cycle pulse
- overflow  out  1  sticky: a beat was dropped
- dup_err  out  1  sticky: a slot was committed twice in a frame
- seq_err  out  1  sticky: an accepted beat was not in row-major (row, tile) order

Behaviour:
- Reset (rst low, asynchronous): all outputs 0; O_mem_addr = O_BASE; FIFO empty; bitmap cleared; expected-order counter = 0.
- Push:
  - in_valid at an edge writes {row, tile, vec} into the FIFO if not full.
  - When full, a pop on the same edge frees a slot and the push is accepted.
  - Otherwise the beat is dropped and overflow sets.
  - A dropped beat does not advance the order counter.
- Write stage:
  - One register holding addr/data/we.
  - Loads from the FIFO head at an edge when the stage is empty or its write commits on that edge. This is a pop.
  - O_mem_we stays high with stable addr/wdata until granted.
  - The grant is sampled at the edge.
- Latency:
  - With FIFO empty and gnt=1, a beat sampled at edge k appears on O_mem_we/addr after edge k+1 and commits at edge k+2.
  - Sustained throughput is 1 beat/cycle when gnt=1.
- Address: O_BASE + {row, tile}, modulo 128 (wraps).
- Commit:
  - Sets bitmap[{row, tile}].
  - If the bit was already set, dup_err sets and written_cnt does not increment.
  - Otherwise written_cnt increments.
- Order check:
  - expected = 7-bit counter over {row, tile}.
  - Each accepted push compares against expected; on mismatch seq_err sets.
  - The counter then resyncs to accepted {row, tile} + 1, wrapping 127 -> 0.
- frame_done: pulses one cycle after the edge where written_cnt becomes 128. written_cnt holds at 128 until frame_start.
- frame_start:
  - Synchronously clears FIFO, write stage (we=0), bitmap, written_cnt, order counter and all sticky flags.
  - A write committing on the same edge is discarded from the accounting.
  - An in_valid on the same cycle is accepted as the first beat of the new frame, with the order check against 0.
- Reset mid-frame: all state is lost; the SRAM contents are untouched.

Test Plan:
- Reset, then frame_start and 128 in-order beats, one every 20 cycles, gnt=1, vec = {4{row*32+tile}} -> 128 writes, addr 0..127 with matching data, written_cnt=128, one frame_done pulse, no error flags.
- gnt=0 for 10 cycles with beats arriving back-to-back, FIFO_DEPTH=4 -> first 5 beats held (4 in FIFO + 1 in stage), 6th beat dropped, overflow=1, fifo_level=4; after gnt=1, 5 writes in order.
- FIFO full, gnt=1 and in_valid on the same edge -> push accepted, overflow stays 0.
- Send (row=1, tile=3) twice -> dup_err=1, written_cnt unchanged by the second commit, seq_err=1 on the second beat.
- O_BASE=7'd64, beat (row=2, tile=5) -> O_mem_addr = 64+69 = 133 mod 128 = 5.
- Mid-frame: 40 beats committed, then frame_start together with beat (0,0) -> written_cnt restarts at 1 after commit, flags cleared, no seq_err.

Source files
------------

// File: rtl/attn_out_stream_writer.sv
// Attention-output stream sink: buffers (row, tile) vectors in a small FIFO and writes them into
// the output SRAM through a granted port, tracking slot coverage and protocol errors per frame.
module attn_out_stream_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [6:0]  O_BASE     = 7'd0,
  parameter int unsigned SLOTS      = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic [127:0]                  in_vec,
  input  logic [1:0]                    in_row,
  input  logic [4:0]                    in_tile,
  input  logic                          in_valid,
  output logic [6:0]                    O_mem_addr,
  output logic [127:0]                  O_mem_wdata,
  output logic                          O_mem_we,
  input  logic                          O_mem_gnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    written_cnt,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overflow,
  output logic                          dup_err,
  output logic                          seq_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] DepthW = FIFO_DEPTH[PtrW:0];

  typedef struct packed {
    logic [6:0]   slot;
    logic [127:0] vec;
  } entry_t;

  entry_t            fifo_mem [FIFO_DEPTH];
  entry_t            head, in_entry;
  logic [PtrW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
  logic [PtrW-1:0]   wr_idx;
  logic              full, empty, pop, push, commit;
  logic              stage_we_q, stage_we_d;
  logic [6:0]        stage_slot_q, stage_slot_d;
  logic [127:0]      stage_data_q, stage_data_d;
  logic [SLOTS-1:0]  bitmap_q, bitmap_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [6:0]        exp_q, exp_d, exp_base;
  logic              done_q, done_d, ovf_q, ovf_d, dup_q, dup_d, seq_q, seq_d;

  always_comb begin
    in_entry = {in_row, in_tile, in_vec};
    level    = wr_ptr_q - rd_ptr_q;
    full     = (level == DepthW);
    empty    = (level == '0);
    head     = fifo_mem[rd_ptr_q[PtrW-1:0]];
    // frame_start flushes everything, so nothing is popped or committed on that edge
    pop      = !empty && (!stage_we_q || O_mem_gnt) && !frame_start;
    commit   = stage_we_q && O_mem_gnt && !frame_start;
    push     = in_valid && (frame_start || !full || pop);
    wr_idx   = frame_start ? '0 : wr_ptr_q[PtrW-1:0];

    if (frame_start) begin
      rd_ptr_d = '0;
      wr_ptr_d = {{PtrW{1'b0}}, push};
    end else begin
      rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, pop};
      wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, push};
    end

    stage_we_d   = stage_we_q;
    stage_slot_d = stage_slot_q;
    stage_data_d = stage_data_q;
    if (frame_start) begin
      stage_we_d = 1'b0;
    end else if (pop) begin
      stage_we_d   = 1'b1;
      stage_slot_d = head.slot;
      stage_data_d = head.vec;
    end else if (commit) begin
      stage_we_d = 1'b0;
    end

    bitmap_d = bitmap_q;
    cnt_d    = cnt_q;
    dup_d    = dup_q;
    done_d   = 1'b0;
    if (frame_start) begin
      bitmap_d = '0;
      cnt_d    = '0;
      dup_d    = 1'b0;
    end else if (commit) begin
      if (bitmap_q[stage_slot_q]) begin
        dup_d = 1'b1;
      end else begin
        bitmap_d[stage_slot_q] = 1'b1;
        cnt_d  = cnt_q + 8'd1;
        done_d = (cnt_q == 8'(SLOTS - 1));
      end
    end

    ovf_d    = frame_start ? 1'b0 : (ovf_q | (in_valid && !push));
    exp_base = frame_start ? 7'd0 : exp_q;
    seq_d    = frame_start ? 1'b0 : seq_q;
    exp_d    = exp_base;
    if (push) begin
      if (in_entry.slot != exp_base) seq_d = 1'b1;
      exp_d = in_entry.slot + 7'd1;
    end
  end

  // Storage carries no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_idx] <= in_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      stage_we_q   <= 1'b0;
      stage_slot_q <= '0;
      stage_data_q <= '0;
      bitmap_q     <= '0;
      cnt_q        <= '0;
      exp_q        <= '0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      dup_q        <= 1'b0;
      seq_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      stage_we_q   <= stage_we_d;
      stage_slot_q <= stage_slot_d;
      stage_data_q <= stage_data_d;
      bitmap_q     <= bitmap_d;
      cnt_q        <= cnt_d;
      exp_q        <= exp_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      dup_q        <= dup_d;
      seq_q        <= seq_d;
    end
  end

  assign O_mem_addr  = O_BASE + stage_slot_q;
  assign O_mem_wdata = stage_data_q;
  assign O_mem_we    = stage_we_q;
  assign fifo_level  = level;
  assign written_cnt = cnt_q;
  assign busy        = !empty || stage_we_q;
  assign frame_done  = done_q;
  assign overflow    = ovf_q;
  assign dup_err     = dup_q;
  assign seq_err     = seq_q;

endmodule
